// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// with sign fix-up and flag generation in a single FIX cycle before DONE.
module muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             z,
  output logic             n,
  output logic             ov,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, divz_q, divz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               z_q, z_d, n_q, n_d, ov_q, ov_d, dz_q, dz_d;

  logic [1:0]         op_in;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_u, rem_u, quo_s, rem_s, dz_hi;
  logic               res_neg;

  // Next-state, datapath step and result/flag computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    divz_d  = divz_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    z_d     = z_q;
    n_d     = n_q;
    ov_d    = ov_q;
    dz_d    = dz_q;

    op_in = {op[1], op[0] & SIGNED_EN};
    sa    = op_in[0] & a[WIDTH-1];
    sb    = op_in[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;

    // opnd_q is the multiplicand for mul and the divisor for div
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_q};

    res_neg = op_q[0] & (neg_a_q ^ neg_b_q);
    prod_s  = res_neg ? -acc_q : acc_q;
    quo_u   = acc_q[WIDTH-1:0];
    rem_u   = acc_q[2*WIDTH-1:WIDTH];
    quo_s   = res_neg ? -quo_u : quo_u;
    rem_s   = (op_q[0] & neg_a_q) ? -rem_u : rem_u;
    dz_hi   = neg_a_q ? -quo_u : quo_u;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d    = op_in;
          neg_a_d = sa;
          neg_b_d = sb;
          divz_d  = op_in[1] & (b == {WIDTH{1'b0}});
          opnd_d  = op_in[1] ? mag_b : mag_a;
          acc_d   = {{WIDTH{1'b0}}, (op_in[1] ? mag_a : mag_b)};
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = (op_in[1] & (b == {WIDTH{1'b0}})) ? S_FIX : S_ITER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (op_q[1]) begin
          if (!diff[WIDTH]) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
        if (divz_q) begin
          hi_d = dz_hi;
          lo_d = {WIDTH{1'b1}};
          z_d  = 1'b0;
          n_d  = 1'b1;
          ov_d = 1'b0;
          dz_d = 1'b1;
        end else if (op_q[1]) begin
          hi_d = rem_s;
          lo_d = quo_s;
          z_d  = (quo_s == {WIDTH{1'b0}});
          n_d  = quo_s[WIDTH-1];
          // a positive signed quotient with its MSB set only arises from MIN / -1
          ov_d = op_q[0] & ~(neg_a_q ^ neg_b_q) & quo_u[WIDTH-1];
          dz_d = 1'b0;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
          z_d  = (prod_s == {(2*WIDTH){1'b0}});
          n_d  = prod_s[2*WIDTH-1];
          ov_d = op_q[0] ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                         : (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          dz_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 2'b00;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      divz_q  <= 1'b0;
      opnd_q  <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      divz_q  <= divz_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      z_q     <= z_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign z    = z_q;
  assign n    = n_q;
  assign ov   = ov_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a 32-bit and an 8-bit instance, directed vectors,
// multi-cycle corner sequences and random ops against an arithmetic model.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, start8 = 1'b0;
  logic [1:0]  op32 = 2'b00, op8 = 2'b00;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        busy32, done32, z32, n32, ov32, dz32;
  logic        busy8, done8, z8, n8, ov8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_mis = 0;

  muldiv_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32),
    .z(z32), .n(n32), .ov(ov32), .dz(dz32));

  muldiv_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
    .z(z8), .n(n8), .ov(ov8), .dz(dz8));

  typedef struct {
    int          w;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [3:0]  fl;  // {z, n, ov, dz}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] get_hi(input int w);
    return (w == 32) ? hi32 : {24'd0, hi8};
  endfunction
  function automatic logic [31:0] get_lo(input int w);
    return (w == 32) ? lo32 : {24'd0, lo8};
  endfunction
  function automatic logic [3:0] get_fl(input int w);
    return (w == 32) ? {z32, n32, ov32, dz32} : {z8, n8, ov8, dz8};
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction

  // Reference model: plain signed/unsigned arithmetic on 64-bit integers
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic [3:0] fl);
    longint mask = (longint'(1) << w) - 1;
    longint minv = -(longint'(1) << (w - 1));
    longint as_, bs_, p, q, r;
    logic z, n, ov, dz;
    as_ = longint'(a) & mask;
    bs_ = longint'(b) & mask;
    if (op[0] && a[w-1]) as_ = as_ - (longint'(1) << w);
    if (op[0] && b[w-1]) bs_ = bs_ - (longint'(1) << w);
    dz = 1'b0;
    ov = 1'b0;
    if (!op[1]) begin
      p  = as_ * bs_;
      hi = 32'((p >>> w) & mask);
      lo = 32'(p & mask);
      z  = (hi == 32'd0) && (lo == 32'd0);
      n  = hi[w-1];
      ov = op[0] ? ((p < minv) || (p > -minv - 1)) : (hi != 32'd0);
    end else if (bs_ == 0) begin
      hi = 32'(as_ & mask);
      lo = 32'(mask);
      z  = 1'b0;
      n  = 1'b1;
      dz = 1'b1;
    end else if (op[0] && as_ == minv && bs_ == -1) begin
      hi = 32'd0;
      lo = 32'(as_ & mask);
      z  = 1'b0;
      n  = 1'b1;
      ov = 1'b1;
    end else begin
      q  = as_ / bs_;
      r  = as_ % bs_;
      hi = 32'(r & mask);
      lo = 32'(q & mask);
      z  = (lo == 32'd0);
      n  = lo[w-1];
    end
    fl = {z, n, ov, dz};
  endfunction

  task automatic drive(input int w, input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      start32 = s; op32 = op; a32 = a; b32 = b;
    end else begin
      start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic wait_done(input int w, output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one op, wait for done, then let the DONE cycle pass
  task automatic run_op(input string tag, input int w, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic [3:0] efl);
    int lat;
    int elat;
    elat = (op[1] && (b == 32'd0)) ? 1 : w + 1;
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, op, a, b);
    check({tag, "_busy"}, {31'd0, get_busy(w)}, 32'd1);
    wait_done(w, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_hi"}, get_hi(w), ehi);
    check({tag, "_lo"}, get_lo(w), elo);
    check({tag, "_flags"}, {28'd0, get_fl(w)}, {28'd0, efl});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, get_done(w)}, 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic [31:0] mh, ml, ra, rb;
    logic [3:0]  mf;
    logic [1:0]  rop;
    int w;

    vecs[0]  = '{32, 2'b00, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE, 4'b0010};
    vecs[1]  = '{32, 2'b01, 32'hFFFFFFF9, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFEB, 4'b0100};
    vecs[2]  = '{32, 2'b11, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 4'b0100};
    vecs[3]  = '{32, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 4'b0110};
    vecs[4]  = '{8,  2'b10, 32'h64,       32'h0,        32'h64,       32'hFF,       4'b0101};
    vecs[5]  = '{8,  2'b10, 32'h64,       32'h7,        32'h02,       32'h0E,       4'b0000};
    vecs[6]  = '{32, 2'b00, 32'h0,        32'h5,        32'h0,        32'h0,        4'b1000};
    vecs[7]  = '{8,  2'b01, 32'h80,       32'h80,       32'h40,       32'h00,       4'b0010};
    vecs[8]  = '{8,  2'b11, 32'hF9,       32'h02,       32'hFF,       32'hFD,       4'b0100};
    vecs[9]  = '{8,  2'b11, 32'h07,       32'hFE,       32'h01,       32'hFD,       4'b0100};
    vecs[10] = '{8,  2'b11, 32'h80,       32'h00,       32'h80,       32'hFF,       4'b0101};
    vecs[11] = '{8,  2'b00, 32'hFF,       32'hFF,       32'hFE,       32'h01,       4'b0110};

    @(posedge clk); #1;
    check("rst_state32", {busy32, done32, z32, n32, ov32, dz32, hi32[25:0]}, 32'd0);
    check("rst_lo32", lo32, 32'd0);
    check("rst_state8", {8'd0, busy8, done8, z8, n8, ov8, dz8, 2'd0, hi8, lo8}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].fl);

    // Start held high through busy, operands changed mid-flight
    @(negedge clk);
    drive(8, 1'b1, 2'b10, 32'h64, 32'h07);
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h03;
    wait_done(8, lat);
    start8 = 1'b0;
    check("hold_lat", lat, 9);
    check("hold_lo", get_lo(8), 32'h0E);
    check("hold_hi", get_hi(8), 32'h02);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) cnt++;
    end
    check("hold_extra_done", cnt, 0);
    check("hold_idle_busy", {31'd0, busy8}, 32'd0);

    // Back-to-back: new start in the DONE cycle
    @(negedge clk);
    drive(8, 1'b1, 2'b10, 32'h64, 32'h07);
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done(8, lat);
    check("b2b_first_lo", get_lo(8), 32'h0E);
    drive(8, 1'b1, 2'b10, 32'hC8, 32'h0B);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_busy", {31'd0, busy8}, 32'd1);
    check("b2b_lo_held", get_lo(8), 32'h0E);
    wait_done(8, lat);
    check("b2b_lat", lat + 1, 10);
    check("b2b_lo", get_lo(8), 32'h12);
    check("b2b_hi", get_hi(8), 32'h02);

    // Random ops against the model
    for (int i = 0; i < 240; i++) begin
      w   = (i % 3 == 0) ? 32 : 8;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: begin ra = 32'h80000000 >> (32 - w); rb = 32'hFFFFFFFF; end
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (w == 8) begin
        ra = ra & 32'hFF;
        rb = rb & 32'hFF;
      end
      model(w, rop, ra, rb, mh, ml, mf);
      run_op($sformatf("rnd%0d_w%0d_op%0d", i, w, rop), w, rop, ra, rb, mh, ml, mf);
    end

    // Asynchronous reset mid-ITER
    @(negedge clk);
    drive(32, 1'b1, 2'b00, 32'd3, 32'd5);
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst32_ctl", {26'd0, busy32, done32, z32, n32, ov32, dz32}, 32'd0);
    check("midrst32_hi", hi32, 32'd0);
    check("midrst32_lo", lo32, 32'd0);
    check("midrst8", {16'd0, hi8, lo8}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done32 || busy32) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_op("post_rst", 32, 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide unit; width-parametrised successor to the single-cycle ALU.
- Sits beside the ALU in the multicycle datapath. The controller issues an operation with a start pulse, holds in a wait state while busy is high, then writes hi/lo to the register file on done.
- Produces zero, negative, overflow and divide-by-zero flags for the flag register.

Parameters:
- WIDTH, 32: operand width; hi/lo are each WIDTH bits; must be >= 4.
- SIGNED_EN, 1: 1 enables the signed ops; 0 forces op[0]=0 (all ops unsigned), which lets synthesis drop the sign-fix logic.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- start  input  1  request; sampled only in IDLE or DONE
- op  input  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high in ITER and FIX
- done  output  1  one-cycle pulse; hi/lo/flags valid from this cycle
- hi  output  WIDTH  mul: upper product half; div: remainder
- lo  output  WIDTH  mul: lower product half; div: quotient
- z  output  1  mul: {hi,lo}==0; div: quotient==0
- n  output  1  mul: hi[WIDTH-1]; div: lo[WIDTH-1]
- ov  output  1  mul: product does not fit in WIDTH bits; div: signed MIN/-1
- dz  output  1  divide by zero (div ops only)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, hi, lo, z, n, ov, dz all 0; iteration counter 0.
- States: IDLE, ITER, FIX, DONE.
- Acceptance: at an edge where state is IDLE or DONE and start=1, latch op/a/b and go to ITER with counter=WIDTH-1.
  - start in ITER or FIX is ignored.
  - The operation in flight is not disturbed by start or by operand changes.
- Signed ops: operands are converted to magnitudes at accept; sign bits are recorded.
- ITER, one radix-2 step per cycle, WIDTH cycles total:
  - mul: shift-add on a 2*WIDTH accumulator.
  - div: restoring shift-subtract on a WIDTH+1-bit partial remainder.
  - When counter==0, go to FIX; otherwise decrement the counter.
- FIX, one cycle: apply result signs, compute flags, register hi/lo/flags; go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 here is accepted (back-to-back operation, no IDLE cycle).
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+WIDTH+1. Back-to-back throughput is one result per WIDTH+2 cycles.
- Outputs hi/lo/flags hold their last values until the next FIX; they are never cleared by a new start.
- Signed division rules:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - a=MIN, b=-1 → lo=MIN, hi=0, ov=1.
- Divide by zero (b==0, op[1]=1):
  - Skips ITER: accept → FIX directly, so done appears after edge E0+1.
  - lo=all ones, hi=a, dz=1, ov=0.
- mul ov:
  - Unsigned: hi!=0.
  - Signed: hi is not the sign extension of lo[WIDTH-1].
- dz is 0 for all mul ops.
- Reset asserted mid-operation aborts immediately to the reset state. No done is produced for the aborted operation.

Test Plan:
- Reset: hold rst=0 mid-ITER → busy/done/hi/lo/flags=0 immediately, without waiting for a clock edge; after release, state is IDLE.
- WIDTH=32, op=00, a=0xFFFFFFFF, b=2 → done 34 cycles after accept; hi=1, lo=0xFFFFFFFE, ov=1, z=0.
- WIDTH=32, op=01, a=-7, b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21), n=1, ov=0.
- WIDTH=32, op=11, a=-7, b=2 → lo=-3, hi=-1.
- WIDTH=32, op=11, a=0x80000000, b=-1 → lo=0x80000000, hi=0, ov=1.
- WIDTH=8, op=10, a=0x64, b=0 → done 2 cycles after accept; lo=0xFF, hi=0x64, dz=1.
- WIDTH=8, op=10, a=0x64, b=7 → lo=14, hi=2, done after 10 cycles.
  - Start held high through busy: exactly one operation is performed.
  - Start asserted in the DONE cycle: a second result follows 10 cycles later.
